// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies use one combinational product and skip the iteration phase.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int RAWIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    input  logic [RAWIDTH-1:0] rd_in,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result,
    output logic [RAWIDTH-1:0] rd_out
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2:0]          f3_q, f3_d;
    logic [RAWIDTH-1:0]  rd_lat_q, rd_lat_d;
    logic                neg_q, neg_d, special_q, special_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [RAWIDTH-1:0]  rd_out_q, rd_out_d;

    logic                sa_s, sb_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s, div_val_s;
    logic [XLEN:0]       mul_sum_s, div_hi_s, div_diff_s;
    logic [2*XLEN-1:0]   prod_s;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic s);
        return (s && v[XLEN-1]) ? (~v + ONE_X) : v;
    endfunction

    // Next-state, iteration datapath and final result formation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        f3_d       = f3_q;
        rd_lat_d   = rd_lat_q;
        neg_d      = neg_q;
        special_d  = special_q;
        done_d     = 1'b0;
        result_d   = result_q;
        rd_out_d   = rd_out_q;

        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin sa_s = 1'b1; sb_s = 1'b1; end
            3'b010:                         begin sa_s = 1'b1; sb_s = 1'b0; end
            default:                        begin sa_s = 1'b0; sb_s = 1'b0; end
        endcase
        a_neg_s = sa_s & op_a[XLEN-1];
        b_neg_s = sb_s & op_b[XLEN-1];
        a_mag_s = magnitude(op_a, sa_s);
        b_mag_s = magnitude(op_b, sb_s);

        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        div_hi_s   = acc_q[2*XLEN-1:XLEN-1];
        div_diff_s = div_hi_s - {1'b0, b_q};
        prod_s     = neg_q ? (~acc_q + ONE_2X) : acc_q;
        div_val_s  = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (neg_q) begin
            div_val_s = ~div_val_s + ONE_X;
        end else begin
            div_val_s = div_val_s;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    f3_d      = funct3;
                    rd_lat_d  = rd_in;
                    cnt_d     = {CNT_W{1'b0}};
                    a_d       = a_mag_s;
                    b_d       = b_mag_s;
                    special_d = 1'b0;
                    if (funct3[2]) begin
                        neg_d   = funct3[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                        acc_d   = {{XLEN{1'b0}}, a_mag_s};
                        state_d = S_CALC;
                        // Zero divisor and signed overflow resolve at capture
                        if (op_b == {XLEN{1'b0}}) begin
                            acc_d     = {{XLEN{1'b0}}, (funct3[1] ? op_a : ONES_X)};
                            neg_d     = 1'b0;
                            special_d = 1'b1;
                            state_d   = S_DONE;
                        end else if (!funct3[0] && op_a == MIN_X && op_b == ONES_X) begin
                            acc_d     = {{XLEN{1'b0}}, (funct3[1] ? {XLEN{1'b0}} : MIN_X)};
                            neg_d     = 1'b0;
                            special_d = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        neg_d = a_neg_s ^ b_neg_s;
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
                        state_d = S_DONE;
`else
                        acc_d   = {{XLEN{1'b0}}, b_mag_s};
                        state_d = S_CALC;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (f3_q[2]) begin
                    if (!div_diff_s[XLEN]) begin
                        acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (special_q) begin
                    result_d = acc_q[XLEN-1:0];
                end else if (f3_q[2]) begin
                    result_d = div_val_s;
                end else if (f3_q[1:0] == 2'b00) begin
                    result_d = prod_s[XLEN-1:0];
                end else begin
                    result_d = prod_s[2*XLEN-1:XLEN];
                end
                rd_out_d = rd_lat_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) | done_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            a_q       <= {XLEN{1'b0}};
            b_q       <= {XLEN{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            f3_q      <= 3'b000;
            rd_lat_q  <= {RAWIDTH{1'b0}};
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            rd_out_q  <= {RAWIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            f3_q      <= f3_d;
            rd_lat_q  <= rd_lat_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared at done.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .RAWIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, za, zb, p;
        logic signed [31:0] sa, sbv;
        ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b};
        za = {32'h0, a};       zb = {32'h0, b};
        sa = a; sbv = b;
        case (f)
            3'd0: begin p = ea * eb; return p[31:0]; end
            3'd1: begin p = ea * eb; return p[63:32]; end
            3'd2: begin p = ea * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sbv;
            end
            3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sbv;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 32'h0) return SPC_LAT;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return SPC_LAT;
        return DIV_LAT;
    endfunction

    // Called at a negedge; issues one request and checks it against the scoreboard.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int lat, input string name);
        exp_t e;
        int   c;
        logic got;
        e.res = exp_res; e.rd = rd; e.lat = lat;
        sb_q.push_back(e);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        c = 0; got = 1'b0;
        while (!got && c < 100) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles (required latency %0d)", name, c, e.lat);
        end else begin
            if (result !== e.res) begin
                errors++;
                $display("FAIL %s result: got %h required %h", name, result, e.res);
            end
            checks++;
            if (rd_out !== e.rd) begin
                errors++;
                $display("FAIL %s rd_out: got %0d required %0d", name, rd_out, e.rd);
            end
            checks++;
            if (c != e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, c, e.lat);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_at_done: got %b required 1", name, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h rd_out=%0d required 0 0 0 0",
                     busy, done, result, rd_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB, MUL_LAT, "mul_7_m3");
        run_op(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1, 32'h00000000, MUL_LAT, "mulh");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, MUL_LAT, "mulhsu");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h7FFFFFFF, MUL_LAT, "mulhu");
    endtask

    task automatic test_div();
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, DIV_LAT, "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF, DIV_LAT, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14, DIV_LAT, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2, DIV_LAT, "remu_100_7");
    endtask

    task automatic test_special();
        run_op(3'd4, 32'h1234, 32'h0, 5'd10, 32'hFFFFFFFF, SPC_LAT, "div_by_zero");
        run_op(3'd7, 32'h1234, 32'h0, 5'd11, 32'h00001234, SPC_LAT, "remu_by_zero");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, SPC_LAT, "div_overflow");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, SPC_LAT, "rem_overflow");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            run_op(f, a, b, 5'(i + 14), model(f, a, b), lat_of(f, a, b), "random");
        end
    endtask

    task automatic test_back_to_back();
        int   c;
        int   dones;
        int   first_c;
        logic [31:0] first_res;
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd20; start = 1'b1;
        c = 0; dones = 0; first_c = 0; first_res = 32'h0;
        while (dones == 0 && c < 100) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c == 5) begin
                funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd21; start = 1'b1;
            end
            if (done === 1'b1) begin
                dones++; first_c = c; first_res = result;
            end
        end
        checks++;
        if (dones != 1 || first_res !== 32'd14 || first_c != DIV_LAT) begin
            errors++;
            $display("FAIL ignored_start: dones=%0d result=%h latency=%0d required 1 %h %0d",
                     dones, first_res, first_c, 32'd14, DIV_LAT);
        end
        funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd22; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_cycle: busy=%b done=%b required 0 0", busy, done);
        end
        run_op(3'd0, 32'd5, 32'd6, 5'd22, 32'd30, MUL_LAT, "start_after_done");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 32'hFFFFFFFE, MUL_LAT, "b2b_mulhu");
    endtask

    task automatic test_abort();
        int c;
        int late_dones;
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b result=%h rd_out=%0d required 0 0 0 0",
                     busy, done, result, rd_out);
        end
        late_dones = 0;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) late_dones++;
        end
        checks++;
        if (late_dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles %0d required 0", late_dones);
        end
        run_op(3'd4, 32'd1000, 32'd3, 5'd26, 32'd333, DIV_LAT, "after_abort");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits downstream of the register file.
- Consumes the two source-register read values and produces a write-back result plus destination address for the register file write port.
- Multi-cycle; raises busy so the core control stalls the PC and holds register write enable low until done.
- Handles all eight M-extension ops selected by funct3.

Parameters:
- XLEN, 32, operand and result width
- RAWIDTH, 5, destination register address width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (register file DataA)
- op_b  input  XLEN  rs2 value (register file DataB)
- rd_in  input  RAWIDTH  destination register of the request
- busy  output  1  high while a request is in flight (CALC or DONE)
- done  output  1  one-cycle pulse; result and rd_out are valid this cycle
- result  output  XLEN  write-back data, held after done until the next accepted start
- rd_out  output  RAWIDTH  captured rd_in, held like result

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, rd_out=0, counter=0, all internal operand registers=0.
- rst has priority over every other input and aborts an in-flight operation; no done is produced for the aborted request.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 at edge k latches funct3, op_a, op_b and rd_in. Next state is CALC, or DONE for a special case (see below).
  - CALC: one iteration per cycle for XLEN cycles, counted by a log2(XLEN)+1-bit counter. After the last iteration, go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle; result is final. Next state is IDLE.
- Normal latency: start at edge k gives done high in the cycle after edge k+XLEN+1 (34 cycles start-to-done for XLEN=32).
- start while busy=1 is ignored; it is not queued.
- start in the DONE cycle is also ignored. The earliest back-to-back start is the cycle after done.
- Signed handling:
  - Magnitudes are taken at capture: signed ops use the absolute value of a negative operand.
  - MULHSU treats op_a as signed and op_b as unsigned.
  - The final result is negated in DONE when the sign rule requires it.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(dividend).
- Multiply: shift-add over a 2*XLEN-bit product. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits of the correctly signed product.
- Divide: restoring shift-subtract, one quotient bit per cycle.
- Special cases, detected in IDLE at capture; these skip CALC (start-to-done is 2 cycles):
  - divisor 0: DIV/DIVU return all ones; REM/REMU return op_a unchanged.
  - signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): DIV returns 0x80000000; REM returns 0.
- result and rd_out update only at the DONE transition. Between operations they keep the last value.
- Arithmetic is modulo 2^XLEN. There are no exceptions or flags.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN
- Defined: the four multiply ops use a single combinational XLEN x XLEN multiply. They go IDLE->DONE directly (start-to-done 2 cycles). Divide ops are unchanged.
- Not defined: all ops use the iterative CALC path, with latency as specified above.

Test Plan:
- MUL op_a=7, op_b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done exactly 34 cycles after start (2 with MULDIV_FAST_MUL_EN); rd_out=rd_in.
- MULH/MULHSU/MULHU with op_a=0x80000000, op_b=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0x80000000
  - MULHU -> 0x7FFFFFFF
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divisor 0 with op_a=0x1234: DIV -> 0xFFFFFFFF, REMU -> 0x1234, done 2 cycles after start. Overflow DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Start pulsed again at cycle 5 of a CALC run:
  - the second start is ignored, and exactly one done pulse occurs;
  - the result is that of the first operation;
  - a start in the cycle after done is accepted.
- rst=1 at cycle 10 of CALC:
  - next cycle busy=0, done=0, result=0;
  - no later done pulse;
  - a subsequent start completes normally.
